// File: rtl/wg_inflight_queue_if.sv
// rtl/wg_inflight_queue_if.sv - host, allocator and dispatch signals of the workgroup in-flight queue
interface wg_inflight_queue_if #(
  parameter int WG_ID_WIDTH = 15,
  parameter int DATA_WIDTH  = 64
);
  logic                   host_wg_valid_i;
  logic                   host_wg_ready_o;
  logic [WG_ID_WIDTH-1:0] host_wg_id_i;
  logic [DATA_WIDTH-1:0]  host_wg_data_i;
  logic                   inflight_wg_buffer_alloc_valid_o;
  logic                   inflight_wg_buffer_alloc_available_o;
  logic [WG_ID_WIDTH-1:0] alloc_wg_id_o;
  logic [DATA_WIDTH-1:0]  alloc_wg_data_o;
  logic                   dis_controller_start_alloc_i;
  logic                   dis_controller_alloc_ack_i;
  logic                   dis_controller_wg_alloc_valid_i;
  logic                   dis_controller_wg_rejected_valid_i;
  logic                   dis_controller_wg_dealloc_valid_i;
  logic                   wg_dispatch_valid_o;
  logic [WG_ID_WIDTH-1:0] wg_dispatch_id_o;
  logic [DATA_WIDTH-1:0]  wg_dispatch_data_o;

  modport master (
    output host_wg_valid_i, host_wg_id_i, host_wg_data_i,
    output dis_controller_start_alloc_i, dis_controller_alloc_ack_i,
    output dis_controller_wg_alloc_valid_i, dis_controller_wg_rejected_valid_i,
    output dis_controller_wg_dealloc_valid_i,
    input  host_wg_ready_o, inflight_wg_buffer_alloc_valid_o,
    input  inflight_wg_buffer_alloc_available_o, alloc_wg_id_o, alloc_wg_data_o,
    input  wg_dispatch_valid_o, wg_dispatch_id_o, wg_dispatch_data_o
  );

  modport slave (
    input  host_wg_valid_i, host_wg_id_i, host_wg_data_i,
    input  dis_controller_start_alloc_i, dis_controller_alloc_ack_i,
    input  dis_controller_wg_alloc_valid_i, dis_controller_wg_rejected_valid_i,
    input  dis_controller_wg_dealloc_valid_i,
    output host_wg_ready_o, inflight_wg_buffer_alloc_valid_o,
    output inflight_wg_buffer_alloc_available_o, alloc_wg_id_o, alloc_wg_data_o,
    output wg_dispatch_valid_o, wg_dispatch_id_o, wg_dispatch_data_o
  );
endinterface

// File: rtl/wg_inflight_queue.sv
// rtl/wg_inflight_queue.sv - workgroup descriptor FIFO with allocate/reject/retry dispatch FSM (optional WG_INFLIGHT_REJECT_CNT_EN)
module wg_inflight_queue #(
  parameter int ENTRIES     = 8,
  parameter int WG_ID_WIDTH = 15,
  parameter int DATA_WIDTH  = 64
) (
  input  logic              clk,
  input  logic              rst,
  wg_inflight_queue_if.slave bus
`ifdef WG_INFLIGHT_REJECT_CNT_EN
  ,
  output logic [15:0]       reject_cnt_o
`endif
);

  localparam int PTR_W = $clog2(ENTRIES);
  localparam int CNT_W = PTR_W + 1;
  localparam int ENT_W = WG_ID_WIDTH + DATA_WIDTH;

  typedef enum logic [2:0] {
    S_IDLE,
    S_STAGED,
    S_ALLOCATING,
    S_REJECT_WAIT,
    S_ACK_WAIT
  } state_t;

  state_t                 state;
  logic [ENT_W-1:0]       mem [ENTRIES];
  logic [PTR_W-1:0]       head;
  logic [PTR_W-1:0]       tail;
  logic [CNT_W-1:0]       count;
  logic                   ack_seen;
  logic                   dealloc_seen;
  logic                   alloc_valid_r;
  logic                   alloc_avail_r;
  logic                   disp_valid_r;
  logic [WG_ID_WIDTH-1:0] disp_id_r;
  logic [DATA_WIDTH-1:0]  disp_data_r;
  logic [ENT_W-1:0]       head_entry;
  logic                   push;
  logic                   pop;
  logic                   ack_done;
  logic                   dealloc_done;
`ifdef WG_INFLIGHT_REJECT_CNT_EN
  logic [15:0]            reject_cnt;
`endif

  // A full queue refuses pushes regardless of a same-cycle pop, so ready depends on count alone.
  assign bus.host_wg_ready_o = (count != CNT_W'(ENTRIES));
  assign push = bus.host_wg_valid_i && bus.host_wg_ready_o;
  assign pop  = (state == S_ALLOCATING) && bus.dis_controller_wg_alloc_valid_i;

  assign head_entry                               = mem[head];
  assign bus.alloc_wg_id_o                        = head_entry[DATA_WIDTH +: WG_ID_WIDTH];
  assign bus.alloc_wg_data_o                      = head_entry[DATA_WIDTH-1:0];
  assign bus.inflight_wg_buffer_alloc_valid_o     = alloc_valid_r;
  assign bus.inflight_wg_buffer_alloc_available_o = alloc_avail_r;
  assign bus.wg_dispatch_valid_o                  = disp_valid_r;
  assign bus.wg_dispatch_id_o                     = disp_id_r;
  assign bus.wg_dispatch_data_o                   = disp_data_r;

  // Retry needs both the end-of-attempt ack and a dealloc, which may arrive in either order or together.
  assign ack_done     = ack_seen || bus.dis_controller_alloc_ack_i;
  assign dealloc_done = dealloc_seen || bus.dis_controller_wg_dealloc_valid_i;

`ifdef WG_INFLIGHT_REJECT_CNT_EN
  assign reject_cnt_o = reject_cnt;
`endif

  // Descriptor storage; contents need no reset since count gates every read that matters.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[tail] <= {bus.host_wg_id_i, bus.host_wg_data_i};
    end
  end

  // Pointers, occupancy, dispatch registers and the allocation FSM with registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= S_IDLE;
      head          <= '0;
      tail          <= '0;
      count         <= '0;
      ack_seen      <= 1'b0;
      dealloc_seen  <= 1'b0;
      alloc_valid_r <= 1'b0;
      alloc_avail_r <= 1'b0;
      disp_valid_r  <= 1'b0;
      disp_id_r     <= '0;
      disp_data_r   <= '0;
`ifdef WG_INFLIGHT_REJECT_CNT_EN
      reject_cnt    <= '0;
`endif
    end else begin
      disp_valid_r <= 1'b0;
      if (push) begin
        tail <= tail + 1'b1;
      end
      if (pop) begin
        head <= head + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase

      case (state)
        S_IDLE: begin
          if (count != '0) begin
            state         <= S_STAGED;
            alloc_valid_r <= 1'b1;
          end
        end
        S_STAGED: begin
          if (bus.dis_controller_start_alloc_i) begin
            state         <= S_ALLOCATING;
            alloc_valid_r <= 1'b0;
            alloc_avail_r <= 1'b1;
          end
        end
        S_ALLOCATING: begin
          // A success and a rejection in the same cycle is resolved as a success.
          if (bus.dis_controller_wg_alloc_valid_i) begin
            state         <= S_ACK_WAIT;
            alloc_avail_r <= 1'b0;
            disp_valid_r  <= 1'b1;
            disp_id_r     <= head_entry[DATA_WIDTH +: WG_ID_WIDTH];
            disp_data_r   <= head_entry[DATA_WIDTH-1:0];
          end else if (bus.dis_controller_wg_rejected_valid_i) begin
            state         <= S_REJECT_WAIT;
            alloc_avail_r <= 1'b0;
            ack_seen      <= 1'b0;
            dealloc_seen  <= 1'b0;
`ifdef WG_INFLIGHT_REJECT_CNT_EN
            if (reject_cnt != 16'hFFFF) begin
              reject_cnt <= reject_cnt + 16'd1;
            end
`endif
          end
        end
        S_ACK_WAIT: begin
          // count already reflects the pop taken on the way in.
          if (bus.dis_controller_alloc_ack_i) begin
            if (count != '0) begin
              state         <= S_STAGED;
              alloc_valid_r <= 1'b1;
            end else begin
              state <= S_IDLE;
            end
          end
        end
        S_REJECT_WAIT: begin
          if (ack_done && dealloc_done) begin
            state         <= S_STAGED;
            alloc_valid_r <= 1'b1;
            ack_seen      <= 1'b0;
            dealloc_seen  <= 1'b0;
          end else begin
            ack_seen     <= ack_done;
            dealloc_seen <= dealloc_done;
          end
        end
        default: begin
          state         <= S_IDLE;
          alloc_valid_r <= 1'b0;
          alloc_avail_r <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wg_inflight_queue.sv
// tb/tb_wg_inflight_queue.sv - directed self-checking bench for wg_inflight_queue
module tb_wg_inflight_queue;
  localparam int ENTRIES = 8;
  localparam int IDW     = 15;
  localparam int DW      = 64;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  wg_inflight_queue_if #(.WG_ID_WIDTH(IDW), .DATA_WIDTH(DW)) bus ();

`ifdef WG_INFLIGHT_REJECT_CNT_EN
  logic [15:0] reject_cnt;
  wg_inflight_queue #(.ENTRIES(ENTRIES), .WG_ID_WIDTH(IDW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst(rst), .bus(bus), .reject_cnt_o(reject_cnt)
  );
`else
  wg_inflight_queue #(.ENTRIES(ENTRIES), .WG_ID_WIDTH(IDW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );
`endif

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [IDW-1:0] id, input logic [DW-1:0] data);
    bus.host_wg_valid_i = 1'b1;
    bus.host_wg_id_i    = id;
    bus.host_wg_data_i  = data;
    tick();
    bus.host_wg_valid_i = 1'b0;
  endtask

  task automatic do_start();
    bus.dis_controller_start_alloc_i = 1'b1;
    tick();
    bus.dis_controller_start_alloc_i = 1'b0;
  endtask

  task automatic do_alloc();
    bus.dis_controller_wg_alloc_valid_i = 1'b1;
    tick();
    bus.dis_controller_wg_alloc_valid_i = 1'b0;
  endtask

  task automatic do_reject();
    bus.dis_controller_wg_rejected_valid_i = 1'b1;
    tick();
    bus.dis_controller_wg_rejected_valid_i = 1'b0;
  endtask

  task automatic do_ack();
    bus.dis_controller_alloc_ack_i = 1'b1;
    tick();
    bus.dis_controller_alloc_ack_i = 1'b0;
  endtask

  task automatic do_dealloc();
    bus.dis_controller_wg_dealloc_valid_i = 1'b1;
    tick();
    bus.dis_controller_wg_dealloc_valid_i = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    total++; if (bus.inflight_wg_buffer_alloc_valid_o !== 1'b0) begin bad++; $display("FAIL reset_alloc_valid got=%b exp=0", bus.inflight_wg_buffer_alloc_valid_o); end
    total++; if (bus.inflight_wg_buffer_alloc_available_o !== 1'b0) begin bad++; $display("FAIL reset_available got=%b exp=0", bus.inflight_wg_buffer_alloc_available_o); end
    total++; if (bus.wg_dispatch_valid_o !== 1'b0) begin bad++; $display("FAIL reset_dispatch got=%b exp=0", bus.wg_dispatch_valid_o); end
    total++; if (bus.wg_dispatch_id_o !== 15'd0) begin bad++; $display("FAIL reset_dispatch_id got=%0d exp=0", bus.wg_dispatch_id_o); end
    rst = 1'b0;
    tick();
    total++; if (bus.host_wg_ready_o !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b exp=1", bus.host_wg_ready_o); end
`ifdef WG_INFLIGHT_REJECT_CNT_EN
    total++; if (reject_cnt !== 16'd0) begin bad++; $display("FAIL reset_reject_cnt got=%0d exp=0", reject_cnt); end
`endif
  endtask

  task automatic test_ignored();
    bus.dis_controller_start_alloc_i       = 1'b1;
    bus.dis_controller_alloc_ack_i         = 1'b1;
    bus.dis_controller_wg_alloc_valid_i    = 1'b1;
    bus.dis_controller_wg_rejected_valid_i = 1'b1;
    bus.dis_controller_wg_dealloc_valid_i  = 1'b1;
    tick();
    bus.dis_controller_start_alloc_i       = 1'b0;
    bus.dis_controller_alloc_ack_i         = 1'b0;
    bus.dis_controller_wg_alloc_valid_i    = 1'b0;
    bus.dis_controller_wg_rejected_valid_i = 1'b0;
    bus.dis_controller_wg_dealloc_valid_i  = 1'b0;
    tick();
    total++; if (bus.wg_dispatch_valid_o !== 1'b0) begin bad++; $display("FAIL idle_ignore_dispatch got=%b exp=0", bus.wg_dispatch_valid_o); end
    total++; if (bus.inflight_wg_buffer_alloc_available_o !== 1'b0) begin bad++; $display("FAIL idle_ignore_available got=%b exp=0", bus.inflight_wg_buffer_alloc_available_o); end
    total++; if (bus.inflight_wg_buffer_alloc_valid_o !== 1'b0) begin bad++; $display("FAIL idle_ignore_alloc_valid got=%b exp=0", bus.inflight_wg_buffer_alloc_valid_o); end
  endtask

  task automatic test_single();
    push(15'd5, 64'h0000_0000_0000_00A5);
    total++; if (bus.inflight_wg_buffer_alloc_valid_o !== 1'b0) begin bad++; $display("FAIL single_valid_early got=%b exp=0", bus.inflight_wg_buffer_alloc_valid_o); end
    tick();
    total++; if (bus.inflight_wg_buffer_alloc_valid_o !== 1'b1) begin bad++; $display("FAIL single_valid got=%b exp=1", bus.inflight_wg_buffer_alloc_valid_o); end
    total++; if (bus.alloc_wg_id_o !== 15'd5) begin bad++; $display("FAIL single_head_id got=%0d exp=5", bus.alloc_wg_id_o); end
    total++; if (bus.host_wg_ready_o !== 1'b1) begin bad++; $display("FAIL single_ready got=%b exp=1", bus.host_wg_ready_o); end
    total++; if (bus.wg_dispatch_valid_o !== 1'b0) begin bad++; $display("FAIL single_no_dispatch got=%b exp=0", bus.wg_dispatch_valid_o); end
    do_start();
    total++; if (bus.inflight_wg_buffer_alloc_valid_o !== 1'b0) begin bad++; $display("FAIL single_alloc_valid_drop got=%b exp=0", bus.inflight_wg_buffer_alloc_valid_o); end
    total++; if (bus.inflight_wg_buffer_alloc_available_o !== 1'b1) begin bad++; $display("FAIL single_available got=%b exp=1", bus.inflight_wg_buffer_alloc_available_o); end
    total++; if (bus.alloc_wg_data_o !== 64'hA5) begin bad++; $display("FAIL single_held_data got=%h exp=a5", bus.alloc_wg_data_o); end
    do_alloc();
    total++; if (bus.wg_dispatch_valid_o !== 1'b1) begin bad++; $display("FAIL single_dispatch got=%b exp=1", bus.wg_dispatch_valid_o); end
    total++; if (bus.wg_dispatch_id_o !== 15'd5) begin bad++; $display("FAIL single_dispatch_id got=%0d exp=5", bus.wg_dispatch_id_o); end
    total++; if (bus.wg_dispatch_data_o !== 64'hA5) begin bad++; $display("FAIL single_dispatch_data got=%h exp=a5", bus.wg_dispatch_data_o); end
    total++; if (bus.inflight_wg_buffer_alloc_available_o !== 1'b0) begin bad++; $display("FAIL single_available_drop got=%b exp=0", bus.inflight_wg_buffer_alloc_available_o); end
    do_ack();
    total++; if (bus.wg_dispatch_valid_o !== 1'b0) begin bad++; $display("FAIL single_dispatch_pulse got=%b exp=0", bus.wg_dispatch_valid_o); end
    tick();
    total++; if (bus.inflight_wg_buffer_alloc_valid_o !== 1'b0) begin bad++; $display("FAIL single_empty_idle got=%b exp=0", bus.inflight_wg_buffer_alloc_valid_o); end
  endtask

  task automatic test_back_to_back_fill();
    for (int i = 0; i < ENTRIES; i++) begin
      bus.host_wg_valid_i = 1'b1;
      bus.host_wg_id_i    = 15'(10 + i);
      bus.host_wg_data_i  = 64'(100 + i);
      tick();
    end
    total++; if (bus.host_wg_ready_o !== 1'b0) begin bad++; $display("FAIL fill_ready got=%b exp=0", bus.host_wg_ready_o); end
    bus.host_wg_id_i   = 15'd99;
    bus.host_wg_data_i = 64'd999;
    tick();
    bus.host_wg_valid_i = 1'b0;
    total++; if (bus.host_wg_ready_o !== 1'b0) begin bad++; $display("FAIL fill_ready_held got=%b exp=0", bus.host_wg_ready_o); end
    total++; if (bus.alloc_wg_id_o !== 15'd10) begin bad++; $display("FAIL fill_head got=%0d exp=10", bus.alloc_wg_id_o); end
    for (int i = 0; i < ENTRIES; i++) begin
      total++; if (bus.inflight_wg_buffer_alloc_valid_o !== 1'b1) begin bad++; $display("FAIL fill_staged[%0d] got=%b exp=1", i, bus.inflight_wg_buffer_alloc_valid_o); end
      do_start();
      do_alloc();
      total++; if (bus.wg_dispatch_id_o !== 15'(10 + i)) begin bad++; $display("FAIL fill_order[%0d] got=%0d exp=%0d", i, bus.wg_dispatch_id_o, 10 + i); end
      total++; if (bus.wg_dispatch_data_o !== 64'(100 + i)) begin bad++; $display("FAIL fill_data[%0d] got=%0d exp=%0d", i, bus.wg_dispatch_data_o, 100 + i); end
      total++; if (bus.host_wg_ready_o !== 1'b1) begin bad++; $display("FAIL fill_ready_after_pop[%0d] got=%b exp=1", i, bus.host_wg_ready_o); end
      total++; if (bus.inflight_wg_buffer_alloc_valid_o !== 1'b0) begin bad++; $display("FAIL fill_valid_before_ack[%0d] got=%b exp=0", i, bus.inflight_wg_buffer_alloc_valid_o); end
      do_ack();
    end
    tick();
    total++; if (bus.inflight_wg_buffer_alloc_valid_o !== 1'b0) begin bad++; $display("FAIL fill_dropped_push got=%b exp=0", bus.inflight_wg_buffer_alloc_valid_o); end
  endtask

  task automatic test_reject_retry();
    push(15'd7, 64'h77);
    tick();
    do_start();
    do_reject();
    total++; if (bus.inflight_wg_buffer_alloc_valid_o !== 1'b0) begin bad++; $display("FAIL reject_valid got=%b exp=0", bus.inflight_wg_buffer_alloc_valid_o); end
    total++; if (bus.wg_dispatch_valid_o !== 1'b0) begin bad++; $display("FAIL reject_no_dispatch got=%b exp=0", bus.wg_dispatch_valid_o); end
    do_ack();
    for (int i = 0; i < 2; i++) begin
      total++; if (bus.inflight_wg_buffer_alloc_valid_o !== 1'b0) begin bad++; $display("FAIL reject_wait[%0d] got=%b exp=0", i, bus.inflight_wg_buffer_alloc_valid_o); end
      tick();
    end
    total++; if (bus.inflight_wg_buffer_alloc_valid_o !== 1'b0) begin bad++; $display("FAIL reject_wait_last got=%b exp=0", bus.inflight_wg_buffer_alloc_valid_o); end
    do_dealloc();
    total++; if (bus.inflight_wg_buffer_alloc_valid_o !== 1'b1) begin bad++; $display("FAIL reject_retry_valid got=%b exp=1", bus.inflight_wg_buffer_alloc_valid_o); end
    total++; if (bus.alloc_wg_id_o !== 15'd7) begin bad++; $display("FAIL reject_retry_id got=%0d exp=7", bus.alloc_wg_id_o); end
`ifdef WG_INFLIGHT_REJECT_CNT_EN
    total++; if (reject_cnt !== 16'd1) begin bad++; $display("FAIL reject_cnt_one got=%0d exp=1", reject_cnt); end
`endif
    do_start();
    do_reject();
    bus.dis_controller_alloc_ack_i        = 1'b1;
    bus.dis_controller_wg_dealloc_valid_i = 1'b1;
    tick();
    bus.dis_controller_alloc_ack_i        = 1'b0;
    bus.dis_controller_wg_dealloc_valid_i = 1'b0;
    total++; if (bus.inflight_wg_buffer_alloc_valid_o !== 1'b1) begin bad++; $display("FAIL reject_same_cycle got=%b exp=1", bus.inflight_wg_buffer_alloc_valid_o); end
`ifdef WG_INFLIGHT_REJECT_CNT_EN
    total++; if (reject_cnt !== 16'd2) begin bad++; $display("FAIL reject_cnt_two got=%0d exp=2", reject_cnt); end
`endif
  endtask

  task automatic test_alloc_wins();
    do_start();
    bus.dis_controller_wg_alloc_valid_i    = 1'b1;
    bus.dis_controller_wg_rejected_valid_i = 1'b1;
    tick();
    bus.dis_controller_wg_alloc_valid_i    = 1'b0;
    bus.dis_controller_wg_rejected_valid_i = 1'b0;
    total++; if (bus.wg_dispatch_valid_o !== 1'b1) begin bad++; $display("FAIL both_dispatch got=%b exp=1", bus.wg_dispatch_valid_o); end
    total++; if (bus.wg_dispatch_id_o !== 15'd7) begin bad++; $display("FAIL both_dispatch_id got=%0d exp=7", bus.wg_dispatch_id_o); end
`ifdef WG_INFLIGHT_REJECT_CNT_EN
    total++; if (reject_cnt !== 16'd2) begin bad++; $display("FAIL both_reject_cnt got=%0d exp=2", reject_cnt); end
`endif
    do_ack();
    tick();
    total++; if (bus.inflight_wg_buffer_alloc_valid_o !== 1'b0) begin bad++; $display("FAIL both_idle got=%b exp=0", bus.inflight_wg_buffer_alloc_valid_o); end
  endtask

  task automatic test_reset_mid_alloc();
    push(15'd20, 64'd20);
    push(15'd21, 64'd21);
    push(15'd22, 64'd22);
    do_start();
    total++; if (bus.inflight_wg_buffer_alloc_available_o !== 1'b1) begin bad++; $display("FAIL rstmid_allocating got=%b exp=1", bus.inflight_wg_buffer_alloc_available_o); end
    rst = 1'b1;
    bus.dis_controller_wg_alloc_valid_i = 1'b1;
    tick();
    rst = 1'b0;
    bus.dis_controller_wg_alloc_valid_i = 1'b0;
    total++; if (bus.wg_dispatch_valid_o !== 1'b0) begin bad++; $display("FAIL rstmid_no_dispatch got=%b exp=0", bus.wg_dispatch_valid_o); end
    total++; if (bus.inflight_wg_buffer_alloc_available_o !== 1'b0) begin bad++; $display("FAIL rstmid_available got=%b exp=0", bus.inflight_wg_buffer_alloc_available_o); end
    total++; if (bus.host_wg_ready_o !== 1'b1) begin bad++; $display("FAIL rstmid_ready got=%b exp=1", bus.host_wg_ready_o); end
`ifdef WG_INFLIGHT_REJECT_CNT_EN
    total++; if (reject_cnt !== 16'd0) begin bad++; $display("FAIL rstmid_reject_cnt got=%0d exp=0", reject_cnt); end
`endif
    for (int i = 0; i < 3; i++) begin
      tick();
      total++; if (bus.inflight_wg_buffer_alloc_valid_o !== 1'b0) begin bad++; $display("FAIL rstmid_empty[%0d] got=%b exp=0", i, bus.inflight_wg_buffer_alloc_valid_o); end
      total++; if (bus.wg_dispatch_valid_o !== 1'b0) begin bad++; $display("FAIL rstmid_dispatch[%0d] got=%b exp=0", i, bus.wg_dispatch_valid_o); end
    end
  endtask

  // Scenario sequence.
  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    bus.host_wg_valid_i                    = 1'b0;
    bus.host_wg_id_i                       = '0;
    bus.host_wg_data_i                     = '0;
    bus.dis_controller_start_alloc_i       = 1'b0;
    bus.dis_controller_alloc_ack_i         = 1'b0;
    bus.dis_controller_wg_alloc_valid_i    = 1'b0;
    bus.dis_controller_wg_rejected_valid_i = 1'b0;
    bus.dis_controller_wg_dealloc_valid_i  = 1'b0;
    test_reset();
    test_ignored();
    test_single();
    test_back_to_back_fill();
    test_reject_retry();
    test_alloc_wins();
    test_reset_mid_alloc();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
